mem_sp_ctrl: RTL and testbench

MEM_SP_CTRL -- requirements
Module: mem_sp_ctrl

---
 rtl/mem_sp_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_sp_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sp_ctrl.sv
// -----------------------------------------------------------------------------
// mem_sp_ctrl -- single-port synchronous memory controller with a self-clearing
// sweep. After reset (or an init_req pulse) every word is written with
// INIT_VALUE, one word per cycle. Only after that are accesses accepted.
// Reads are pipelined with a latency of RD_LATENCY (1 or 2) cycles.
//
// Parameters
//   ADDR_WIDTH  address bus width
//   DATA_WIDTH  data word width
//   DEPTH       number of words, 2..2**ADDR_WIDTH
//   RD_LATENCY  read latency in cycles, 1 or 2
//   INIT_VALUE  word written to every location by the clear sweep
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   cs        chip select; an access is requested when high
//   mem_en    access direction: 1 = write, 0 = read
//   addr      word address
//   data_in   write data
//   init_req  single-cycle pulse requesting a clear sweep
//   data_out  read data; holds the last read value between reads
//   rd_valid  one-cycle pulse marking data_out as new
//   ready     high when accesses are accepted
//   addr_err  one-cycle pulse after an out-of-range access
// -----------------------------------------------------------------------------
module mem_sp_ctrl #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 16,
  parameter int                    RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  mem_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  init_req,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  ready,
  output logic                  addr_err
);

  // Index width of the storage array; never wider than the address bus
  // because DEPTH <= 2**ADDR_WIDTH.
  localparam int                    IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    in_range;
  logic                    acc_req;
  logic                    wr_en;
  logic                    rd_req;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   rd_word;

  // ---------------------------------------------------------------------------
  // Request decode. Accesses are only seen while ready is high, so every
  // request arriving during a sweep is dropped here.
  // ---------------------------------------------------------------------------
  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign acc_req  = cs & ready;
  assign wr_en    = acc_req & mem_en & in_range;
  assign rd_req   = acc_req & ~mem_en;
  assign idx      = addr[IDX_W-1:0];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_word = '0;
    if (in_range) begin
      rd_word = mem[idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM. ready is kept as its own flop so it changes together with
  // the state and never glitches.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments only, so all
  // flops sample the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (init_req) begin
            clr_cnt <= '0;
          end else if (clr_cnt == LAST_IDX) begin
            state   <= READY;
            ready   <= 1'b1;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        READY: begin
          // An access presented alongside init_req is still honoured, since
          // ready is high for this edge.
          if (init_req) begin
            state   <= CLEAR;
            ready   <= 1'b0;
            clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. The sweep owns the write port while clearing; user writes only
  // happen in READY.
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; its contents become defined by the clear
  // sweep, which keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= INIT_VALUE;
    end else if (wr_en) begin
      mem[idx] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline, first stage. Out-of-range reads travel through with a
  // zero word so they still produce rd_valid at the normal latency. The data
  // register only loads on a read, so the output holds when idle.
  // ---------------------------------------------------------------------------
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      addr_err <= 1'b0;
    end else begin
      s1_valid <= rd_req;
      addr_err <= acc_req & ~in_range;
      if (rd_req) begin
        s1_data <= rd_word;
      end
    end
  end

  // Second stage only exists for RD_LATENCY == 2. Reads already in flight
  // are unaffected by a sweep starting; only rst_n flushes them.
  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign rd_valid = s2_valid;
    assign data_out = s2_data;
  end else begin : g_lat1
    assign rd_valid = s1_valid;
    assign data_out = s1_data;
  end

endmodule

// File: tb/tb_mem_sp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_sp_ctrl -- self-checking bench for mem_sp_ctrl.
// Two instances share one stimulus stream:
//   u_a : defaults (DEPTH=16, RD_LATENCY=1, INIT_VALUE=0x00)
//   u_b : DEPTH=12, RD_LATENCY=2, INIT_VALUE=0x3C
// A word-level model of each memory produces the expected read data, which is
// queued with its due cycle when a request is driven and popped by a monitor
// when rd_valid / addr_err appear.
// -----------------------------------------------------------------------------
module tb_mem_sp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs;
  logic       mem_en;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic       init_req;

  logic [7:0] data_out_a, data_out_b;
  logic       rd_valid_a, rd_valid_b;
  logic       ready_a, ready_b;
  logic       addr_err_a, addr_err_b;

  always #5 clk = ~clk;

  mem_sp_ctrl u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .mem_en   (mem_en),
    .addr     (addr),
    .data_in  (data_in),
    .init_req (init_req),
    .data_out (data_out_a),
    .rd_valid (rd_valid_a),
    .ready    (ready_a),
    .addr_err (addr_err_a)
  );

  mem_sp_ctrl #(
    .DEPTH      (12),
    .RD_LATENCY (2),
    .INIT_VALUE (8'h3C)
  ) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .mem_en   (mem_en),
    .addr     (addr),
    .data_in  (data_in),
    .init_req (init_req),
    .data_out (data_out_b),
    .rd_valid (rd_valid_b),
    .ready    (ready_b),
    .addr_err (addr_err_b)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    int         due;
  } rd_exp_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [12];
  rd_exp_t    q_a[$];
  rd_exp_t    q_b[$];
  int         e_a[$];
  int         e_b[$];
  rd_exp_t    ea, eb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cs      = 1'b0;
    mem_en  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic load_models();
    for (int i = 0; i < 16; i++) mem_a[i] = 8'h00;
    for (int i = 0; i < 12; i++) mem_b[i] = 8'h3C;
  endtask

  // One accepted access, presented for one cycle. Expectations for both
  // instances are queued at drive time.
  task automatic access(input logic we, input int a, input logic [7:0] d);
    cs      = 1'b1;
    mem_en  = we;
    addr    = a[3:0];
    data_in = d;
    if (we) mem_a[a] = d;
    else    q_a.push_back('{mem_a[a], cyc + 1});
    if (a < 12) begin
      if (we) mem_b[a] = d;
      else    q_b.push_back('{mem_b[a], cyc + 2});
    end else begin
      e_b.push_back(cyc + 1);
      if (!we) q_b.push_back('{8'h00, cyc + 2});
    end
    tick();
  endtask

  // Counts ticks until each instance raises ready; an expired bound shows up
  // as a zero count against the expected one.
  task automatic wait_ready(input int exp_a, input int exp_b, input string tag);
    int n  = 0;
    int ta = 0;
    int tb = 0;
    while ((ta == 0 || tb == 0) && n < 100) begin
      tick();
      n++;
      if (ready_a && ta == 0) ta = n;
      if (ready_b && tb == 0) tb = n;
    end
    check({tag, "_a"}, ta, exp_a);
    check({tag, "_b"}, tb, exp_b);
  endtask

  // ---------------------------------------------------------------------------
  // Output monitors
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid_a) begin
        if (q_a.size() == 0) check("rd_valid_a_unexpected", rd_valid_a, 0);
        else begin
          ea = q_a.pop_front();
          check("rd_a_cycle", cyc, ea.due);
          check("rd_a_data", data_out_a, ea.data);
        end
      end else if (q_a.size() > 0 && q_a[0].due <= cyc) begin
        check("rd_valid_a_missing", rd_valid_a, 1);
        void'(q_a.pop_front());
      end
      if (addr_err_a) begin
        if (e_a.size() == 0) check("addr_err_a_unexpected", addr_err_a, 0);
        else check("addr_err_a_cycle", cyc, e_a.pop_front());
      end else if (e_a.size() > 0 && e_a[0] <= cyc) begin
        check("addr_err_a_missing", addr_err_a, 1);
        void'(e_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid_b) begin
        if (q_b.size() == 0) check("rd_valid_b_unexpected", rd_valid_b, 0);
        else begin
          eb = q_b.pop_front();
          check("rd_b_cycle", cyc, eb.due);
          check("rd_b_data", data_out_b, eb.data);
        end
      end else if (q_b.size() > 0 && q_b[0].due <= cyc) begin
        check("rd_valid_b_missing", rd_valid_b, 1);
        void'(q_b.pop_front());
      end
      if (addr_err_b) begin
        if (e_b.size() == 0) check("addr_err_b_unexpected", addr_err_b, 0);
        else check("addr_err_b_cycle", cyc, e_b.pop_front());
      end else if (e_b.size() > 0 && e_b[0] <= cyc) begin
        check("addr_err_b_missing", addr_err_b, 1);
        void'(e_b.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n, ta, tb;

    rst_n    = 1'b0;
    cs       = 1'b0;
    mem_en   = 1'b0;
    addr     = '0;
    data_in  = '0;
    init_req = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_ready_a",    ready_a,    0);
    check("rst_ready_b",    ready_b,    0);
    check("rst_rd_valid_a", rd_valid_a, 0);
    check("rst_rd_valid_b", rd_valid_b, 0);
    check("rst_data_out_a", data_out_a, 0);
    check("rst_data_out_b", data_out_b, 0);
    check("rst_addr_err_a", addr_err_a, 0);
    check("rst_addr_err_b", addr_err_b, 0);

    // Power-up sweep: DEPTH cycles of CLEAR, then every word reads INIT_VALUE
    rst_n = 1'b1;
    wait_ready(16, 12, "powerup_ready_tick");
    load_models();
    for (int i = 0; i < 16; i++) access(1'b0, i, 8'h00);
    idle(4);

    // Write then read on the next cycle; data_out then holds while idle
    access(1'b1, 3, 8'hA5);
    access(1'b0, 3, 8'h00);
    idle(4);
    check("hold_a", data_out_a, 8'hA5);
    check("hold_b", data_out_b, 8'hA5);

    // cs=0 with mem_en=1 must not write
    cs = 1'b0; mem_en = 1'b1; addr = 4'd3; data_in = 8'hDE;
    tick();
    access(1'b0, 3, 8'h00);
    idle(4);

    // Preload 0x10+addr, then 16 back-to-back reads
    for (int i = 0; i < 16; i++) access(1'b1, i, 8'(16 + i));
    for (int i = 0; i < 16; i++) access(1'b0, i, 8'h00);
    idle(4);

    // Out-of-range write and read (addr 13 is beyond u_b's 12 words)
    access(1'b1, 13, 8'hFF);
    access(1'b0, 13, 8'h00);
    idle(4);
    check("oor_zero_hold_b", data_out_b, 8'h00);
    for (int i = 0; i < 16; i++) access(1'b0, i, 8'h00);
    idle(4);

    // Re-init: read issued with init_req still completes; second init_req
    // restarts the sweep after 7 cleared words; requests meanwhile ignored.
    access(1'b1, 5, 8'h77);
    init_req = 1'b1;
    access(1'b0, 5, 8'h00);
    check("reinit_ready_a_low", ready_a, 0);
    check("reinit_ready_b_low", ready_b, 0);
    n = 1; ta = 0; tb = 0;
    while ((ta == 0 || tb == 0) && n < 100) begin
      cs       = (n < 19);
      mem_en   = n[0];
      addr     = n[1] ? 4'd13 : 4'd5;
      data_in  = 8'hEE;
      init_req = (n == 7);
      tick();
      n++;
      if (ready_a && ta == 0) ta = n;
      if (ready_b && tb == 0) tb = n;
    end
    init_req = 1'b0;
    cs       = 1'b0;
    check("reinit_ready_tick_a", ta, 24);
    check("reinit_ready_tick_b", tb, 20);
    load_models();
    access(1'b0, 5, 8'h00);
    idle(4);
    check("reinit_addr5_b", data_out_b, 8'h3C);

    // Reset one cycle after a read: u_b's read (latency 2) is aborted
    access(1'b0, 7, 8'h00);
    cs = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrd_rd_valid_b", rd_valid_b, 0);
    check("midrd_data_out_b", data_out_b, 0);
    check("midrd_data_out_a", data_out_a, 0);
    check("midrd_ready_b",    ready_b,    0);
    q_a.delete(); q_b.delete(); e_a.delete(); e_b.delete();
    tick();
    tick();
    check("midrd_rd_valid_b_held", rd_valid_b, 0);
    rst_n = 1'b1;
    wait_ready(16, 12, "midrd_sweep_tick");
    load_models();
    access(1'b0, 7, 8'h00);
    idle(4);

    check("final_q_a", q_a.size(), 0);
    check("final_q_b", q_b.size(), 0);
    check("final_e_b", e_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
